// File: rtl/spi_ram_slave_pkg.sv
// Shared SPI definitions: command opcodes and slave FSM states, also used by the CPU fetch master.
package spi_ram_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Byte memory for the SPI RAM slave: one arbitrated write port (SPI over backdoor), one combinational read port.
module spi_ram_array #(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          spi_we,
  input  logic [AW-1:0] spi_addr,
  input  logic [7:0]    spi_wdata,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [7:0]    bd_wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MEM_BYTES];

  // Contents survive reset; on an address collision the SPI write wins.
  always_ff @(posedge clk) begin
    if (bd_we && !(spi_we && (spi_addr == bd_addr))) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (spi_we) begin
      mem[spi_addr] <= spi_wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_ram_slave.sv
// SPI mode-0 RAM slave: synchronised pins, READ (0x03) / WRITE (0x02) with auto-increment and wrap.
module spi_ram_slave
  import spi_ram_slave_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs_n,
  input  logic                         sck,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic                         busy
);

  localparam int unsigned     AW             = $clog2(MEM_BYTES);
  localparam logic [1:0]      LAST_ADDR_BYTE = 2'(ADDR_BYTES - 1);
  localparam logic [AW-1:0]   ADDR_ONE       = AW'(1);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic                   sck_prev_q, sck_prev_d;
  spi_state_e             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [6:0]             shift_in_q, shift_in_d;
  logic [7:0]             shift_out_q, shift_out_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   is_read_q, is_read_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;

  logic          cs_s, sck_s, mosi_s, sck_rise, sck_fall;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr_shift, addr_inc, rd_addr;
  logic [7:0]    rd_data;
  logic          spi_we;

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign rx_byte    = {shift_in_q, mosi_s};
  assign addr_shift = {addr_q[AW-2:0], mosi_s};
  assign addr_inc   = addr_q + ADDR_ONE;
  // In ADDR the read port looks at the address being completed this rise; otherwise at the next byte.
  assign rd_addr    = (state_q == ST_ADDR) ? addr_shift : addr_inc;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    // Only a cs_n seen high after reset arms command decoding, so a held-low cs_n is not a fresh fall.
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    sck_prev_d  = sck_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    spi_we      = 1'b0;

    if (cs_s) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d    = ST_CMD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            shift_in_d = '0;
            addr_d     = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte == CMD_READ) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b1;
              end else if (rx_byte == CMD_WRITE) begin
                state_d   = ST_ADDR;
                is_read_d = 1'b0;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            addr_d    = addr_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == LAST_ADDR_BYTE) begin
                if (is_read_q) begin
                  state_d     = ST_READ;
                  shift_out_d = rd_data;
                  miso_oe_d   = 1'b1;
                end else begin
                  state_d = ST_WRITE;
                end
              end
            end
          end
        end
        ST_READ: begin
          if (sck_fall) begin
            miso_d    = shift_out_q[7];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d      = addr_inc;
              shift_out_d = rd_data;
            end else begin
              shift_out_d = {shift_out_q[6:0], 1'b0};
            end
          end
        end
        ST_WRITE: begin
          if (sck_rise) begin
            shift_in_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              spi_we = 1'b1;
              addr_d = addr_inc;
            end
          end
        end
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != ST_READ) begin
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      sck_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  spi_ram_array #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_array (
    .clk      (clk),
    .spi_we   (spi_we),
    .spi_addr (addr_q),
    .spi_wdata(rx_byte),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign busy    = ~cs_s;

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed + randomized bench for spi_ram_slave: two instances (1-byte/256B and 2-byte/1024B addressing) against byte-array models.
module tb_spi_ram_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n0 = 1'b1, cs_n1 = 1'b1;
  logic       sck = 1'b0, mosi = 1'b0;
  logic       miso0, miso1, oe0, oe1, busy0, busy1;
  logic       bd_we0 = 1'b0, bd_we1 = 1'b0;
  logic [7:0] bd_addr0 = '0;
  logic [9:0] bd_addr1 = '0;
  logic [7:0] bd_wdata = '0;

  logic [7:0] ref0 [256];
  logic [7:0] ref1 [1024];
  logic [7:0] wbuf [4];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_ram_slave #(.MEM_BYTES(256), .ADDR_BYTES(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n0), .sck(sck), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .bd_we(bd_we0), .bd_addr(bd_addr0),
    .bd_wdata(bd_wdata), .busy(busy0)
  );

  spi_ram_slave #(.MEM_BYTES(1024), .ADDR_BYTES(2), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n1), .sck(sck), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .bd_we(bd_we1), .bd_addr(bd_addr1),
    .bd_wdata(bd_wdata), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int sel, input int a);
    return sel ? ref1[a % 1024] : ref0[a % 256];
  endfunction

  task automatic model_wr(input int sel, input int a, input logic [7:0] v);
    if (sel != 0) ref1[a % 1024] = v;
    else          ref0[a % 256]  = v;
  endtask

  task automatic bd_write(input int sel, input int a, input logic [7:0] v);
    @(negedge clk);
    bd_wdata = v;
    if (sel != 0) begin bd_we1 = 1'b1; bd_addr1 = 10'(a); end
    else          begin bd_we0 = 1'b1; bd_addr0 = 8'(a);  end
    model_wr(sel, a, v);
    @(negedge clk);
    bd_we0 = 1'b0;
    bd_we1 = 1'b0;
  endtask

  task automatic cs_low(input int sel);
    if (sel != 0) cs_n1 = 1'b0; else cs_n0 = 1'b0;
    #HALF;
    chk("busy_on", (sel != 0) ? busy1 : busy0, 1);
  endtask

  task automatic cs_high(input int sel);
    #HALF;
    if (sel != 0) cs_n1 = 1'b1; else cs_n0 = 1'b1;
    #(2 * HALF);
    chk("busy_off", (sel != 0) ? busy1 : busy0, 0);
    chk("oe_after_cs", (sel != 0) ? oe1 : oe0, 0);
  endtask

  // Mode 0 master: drive mosi, sample miso just before the rising edge.
  task automatic spi_bits(input int sel, input logic [7:0] tx, input int nb,
                          input logic exp_oe, output logic [7:0] rx);
    logic m, oe;
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7 - i];
      #HALF;
      m  = (sel != 0) ? miso1 : miso0;
      oe = (sel != 0) ? oe1 : oe0;
      rx = {rx[6:0], m};
      chk("miso_oe", oe, exp_oe);
      if (!exp_oe) chk("miso_quiet", m, 0);
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic send_hdr(input int sel, input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] rx;
    spi_bits(sel, cmd, 8, 1'b0, rx);
    if (sel != 0) spi_bits(sel, addr[15:8], 8, 1'b0, rx);
    spi_bits(sel, addr[7:0], 8, 1'b0, rx);
  endtask

  task automatic read_data(input int sel, input logic [15:0] addr, input int n);
    logic [7:0] rx;
    for (int i = 0; i < n; i++) begin
      spi_bits(sel, 8'($urandom), 8, 1'b1, rx);
      chk("rd_byte", rx, model_rd(sel, int'(addr) + i));
    end
  endtask

  task automatic read_txn(input int sel, input logic [15:0] addr, input int n);
    cs_low(sel);
    send_hdr(sel, 8'h03, addr);
    read_data(sel, addr, n);
    cs_high(sel);
  endtask

  task automatic write_txn(input int sel, input logic [15:0] addr, input int n);
    logic [7:0] rx;
    cs_low(sel);
    send_hdr(sel, 8'h02, addr);
    for (int i = 0; i < n; i++) begin
      spi_bits(sel, wbuf[i], 8, 1'b0, rx);
      model_wr(sel, int'(addr) + i, wbuf[i]);
    end
    cs_high(sel);
  endtask

  initial begin
    logic [7:0]  rx, v;
    logic [15:0] a;
    int          sel, n;

    #20;
    chk("rst_miso0", miso0, 0);
    chk("rst_oe0", oe0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_miso1", miso1, 0);
    chk("rst_busy1", busy1, 0);
    #20 rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      case (i)
        0: v = 8'h10;
        1: v = 8'h64;
        2: v = 8'h68;
        3: v = 8'h53;
        default: v = 8'($urandom);
      endcase
      bd_write(0, i, v);
    end
    for (int i = 0; i < 1024; i++) bd_write(1, i, 8'($urandom));
    #100;

    // Sequential read of the preloaded program bytes.
    read_txn(0, 16'h0000, 16);

    // Write with wrap past the top of memory.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
    write_txn(0, 16'h00FE, 3);
    read_txn(0, 16'h00FE, 3);

    // Partial trailing byte must be dropped.
    cs_low(0);
    send_hdr(0, 8'h02, 16'h0010);
    spi_bits(0, 8'h77, 8, 1'b0, rx);
    model_wr(0, 16'h10, 8'h77);
    spi_bits(0, 8'($urandom), 4, 1'b0, rx);
    cs_high(0);
    read_txn(0, 16'h0010, 2);

    // Unknown command: output stays disabled, next read still works.
    cs_low(0);
    spi_bits(0, 8'h9F, 8, 1'b0, rx);
    for (int i = 0; i < 3; i++) spi_bits(0, 8'($urandom), 8, 1'b0, rx);
    cs_high(0);
    read_txn(0, 16'(8'($urandom)), 2);

    // Backdoor write lands while a read is in progress.
    cs_low(0);
    send_hdr(0, 8'h03, 16'h0040);
    bd_write(0, 16'h41, 8'hE7);
    read_data(0, 16'h0040, 2);
    cs_high(0);

    // Reset in the middle of a read data byte.
    cs_low(0);
    send_hdr(0, 8'h03, 16'h0005);
    spi_bits(0, 8'h00, 3, 1'b1, rx);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miso", miso0, 0);
    chk("rst_mid_oe", oe0, 0);
    chk("rst_mid_busy", busy0, 0);
    #19 rst_n = 1'b1;
    #40;
    // cs_n still low from before reset: no command may be decoded.
    send_hdr(0, 8'h03, 16'h0005);
    spi_bits(0, 8'h00, 8, 1'b0, rx);
    cs_high(0);
    read_txn(0, 16'h0005, 1);

    // Two address bytes, upper bits discarded, wrap at 1023.
    read_txn(1, 16'h83FF, 2);

    for (int t = 0; t < 24; t++) begin
      sel = (t % 3 == 2) ? 1 : 0;
      a   = 16'($urandom);
      n   = $urandom_range(1, 4);
      if ($urandom_range(0, 1) != 0) begin
        read_txn(sel, a, n);
      end else begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        write_txn(sel, a, n);
        read_txn(sel, a, n);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave.md
SPI_RAM_SLAVE -- requirements
Module: spi_ram_slave

Interface
REQ-001 Parameter MEM_BYTES, default 256, memory depth in bytes (power of two, 16..4096).
REQ-002 Parameter ADDR_BYTES, default 1, number of address bytes following the command (1..3).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth on cs_n/sck/mosi (2..3).
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 sck  input  1  SPI clock, asynchronous to clk.
REQ-008 mosi  input  1  SPI data in.
REQ-009 miso  output  1  SPI data out.
REQ-010 miso_oe  output  1  high while miso is driven (READ data phase only).
REQ-011 bd_we  input  1  backdoor write strobe, for program preload.
REQ-012 bd_addr  input  clog2(MEM_BYTES)  backdoor address.
REQ-013 bd_wdata  input  8  backdoor write data.
REQ-014 busy  output  1  high whenever synchronised cs_n is low.

Function
REQ-015 cs_n, sck and mosi SHALL pass through SYNC_STAGES flops; sck edges are detected on the synchronised signal; clk SHALL be at least 8x sck.
REQ-016 SPI mode 0, MSB first: mosi sampled on detected sck rise, miso updated on detected sck fall.
REQ-017 FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
REQ-018 IDLE -> CMD on synchronised cs_n fall; bit and byte counters cleared.
REQ-019 CMD: after 8 bits, 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-020 ADDR: collect 8*ADDR_BYTES bits; address bits above clog2(MEM_BYTES) are discarded.
REQ-021 Read: on the rise carrying the last address bit, load the shift register with mem[addr]; enter READ; miso shows bit7 after the next fall, following bits after each subsequent fall.
REQ-022 READ: after each 8th bit output, addr increments modulo MEM_BYTES and the next byte loads, giving unbounded sequential reads with wrap from MEM_BYTES-1 to 0.
REQ-023 WRITE: every 8 sampled bits are written to mem[addr] in one clk, then addr increments modulo MEM_BYTES.
REQ-024 IGNORE: mosi discarded, miso_oe low, until cs_n rises.
REQ-025 Synchronised cs_n rise in any state -> IDLE within one clk; a partial write byte is discarded; a partial read is aborted.
REQ-026 miso SHALL be 0 whenever miso_oe is low.
REQ-027 Backdoor write SHALL take effect in the clk cycle following bd_we high, in any state.
REQ-028 If an SPI write and a backdoor write target the same address in the same clk, the SPI write SHALL win; different addresses both complete.
REQ-029 Latency: miso change no later than SYNC_STAGES+2 clk after the sck falling edge at the pin.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, miso 0, miso_oe 0, busy 0, and clear counters, shift registers, address and synchronisers (cs_n synchronisers to 1).
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-transaction SHALL abort it; after release the slave SHALL wait for a fresh cs_n fall before decoding a command.

Structure
REQ-033 Command opcodes (0x02, 0x03) and the FSM state enumeration SHALL reside in the shared SPI package, reused by the CPU fetch master.
REQ-034 Memory array SHALL be a sub-module spi_ram_array (single write port with SPI/backdoor arbitration, one combinational read port).

Verification
REQ-035 Backdoor preload mem[0x00..0x0F] = 0x10,0x64,0x68,0x53,...; READ 0x03 addr 0x00, 16 bytes -> identical bytes on miso, miso_oe high only in the data phase.
REQ-036 WRITE 0x02 addr 0xFE, data 0xA5,0x5A,0xC3 -> mem[0xFE]=0xA5, mem[0xFF]=0x5A, mem[0x00]=0xC3 (wrap).
REQ-037 WRITE addr 0x10, 8 bits 0x77 then 4 bits, cs_n high -> mem[0x10]=0x77, mem[0x11] unchanged.
REQ-038 Command 0x9F -> miso_oe stays 0 for the whole transaction; next 0x03 transaction reads correctly.
REQ-039 rst_n pulsed low during a READ at bit 3 -> miso=0, miso_oe=0 immediately; a following READ of addr 0x05 returns the preloaded value.
REQ-040 ADDR_BYTES=2, MEM_BYTES=1024: READ addr 0x83FF -> returns mem[0x3FF], then mem[0x000].
